// File: rtl/uart_echo_fifo_if.sv
// uart_echo_fifo_if: byte handshake between the uart rx/tx controls and the echo FIFO
interface uart_echo_fifo_if #(parameter int DATA_W = 8);
    logic              rx_empty;
    logic [DATA_W-1:0] rx_data;
    logic              uld_rx_data;
    logic              tx_empty;
    logic [DATA_W-1:0] tx_data;
    logic              ld_tx_data;
    modport master (output rx_empty, rx_data, tx_empty, input uld_rx_data, tx_data, ld_tx_data);
    modport slave  (input rx_empty, rx_data, tx_empty, output uld_rx_data, tx_data, ld_tx_data);
endinterface

// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo: drains uart rx bytes into a circular FIFO and replays them through uart tx
module uart_echo_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic             clk_50Mhz,
    input  logic             reset,
    uart_echo_fifo_if.slave  uart,
    output logic [ADDR_W:0]  count,
    output logic             overflow
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic [1:0] {R_IDLE, R_UNLD, R_CAPT} r_state_t;
    typedef enum logic {T_IDLE, T_LOAD} t_state_t;
    r_state_t          r_state;
    t_state_t          t_state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              full;
    logic              push;
    logic              pop;
    // full uses the current count, so a pop on the same edge cannot make room for this push
    assign full = count == (ADDR_W+1)'(DEPTH);
    assign push = r_state == R_CAPT && !full;
    assign pop  = t_state == T_LOAD && !uart.tx_empty;
    // RX side: one-cycle unload pulse, then capture the byte the uart presents
    always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
            r_state          <= R_IDLE;
            uart.uld_rx_data <= 1'b0;
            wr_ptr           <= '0;
            overflow         <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (!uart.rx_empty) begin
                        r_state          <= R_UNLD;
                        uart.uld_rx_data <= 1'b1;
                    end
                end
                R_UNLD: begin
                    r_state          <= R_CAPT;
                    uart.uld_rx_data <= 1'b0;
                end
                R_CAPT: begin
                    r_state <= R_IDLE;
                    if (full) overflow <= 1'b1;
                    else wr_ptr <= wr_ptr + 1'b1;
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end
    // FIFO storage; contents need no reset
    always_ff @(posedge clk_50Mhz) begin
        if (push) mem[wr_ptr] <= uart.rx_data;
    end
    // TX side: present the head byte and hold the load request until the uart takes it
    always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
            t_state         <= T_IDLE;
            uart.ld_tx_data <= 1'b0;
            uart.tx_data    <= '0;
            rd_ptr          <= '0;
        end else begin
            case (t_state)
                T_IDLE: begin
                    if (count != '0 && uart.tx_empty) begin
                        t_state         <= T_LOAD;
                        uart.tx_data    <= mem[rd_ptr];
                        uart.ld_tx_data <= 1'b1;
                    end
                end
                T_LOAD: begin
                    if (!uart.tx_empty) begin
                        t_state         <= T_IDLE;
                        uart.ld_tx_data <= 1'b0;
                        rd_ptr          <= rd_ptr + 1'b1;
                    end
                end
                default: t_state <= T_IDLE;
            endcase
        end
    end
    // occupancy; simultaneous push and pop cancel out
    always_ff @(posedge clk_50Mhz) begin
        if (reset) count <= '0;
        else count <= count + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
    end
endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo: uart rx/tx models feed the echo FIFO; a monitor scores transmitted bytes and occupancy
module tb_uart_echo_fifo;
    logic       clk_50Mhz = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] count;
    logic       overflow;
    uart_echo_fifo_if u_if ();
    uart_echo_fifo dut (
        .clk_50Mhz (clk_50Mhz),
        .reset     (reset),
        .uart      (u_if),
        .count     (count),
        .overflow  (overflow)
    );
    always #10 clk_50Mhz = ~clk_50Mhz;
    logic [7:0] rxq[$];
    logic [7:0] exp_q[$];
    int  checks = 0;
    int  errors = 0;
    bit  stall = 1'b0;
    int  delay = 1;
    int  tx_wait = 0;
    bit  rst_seen = 1'b0;
    bit  valid = 1'b0;
    bit  prev_uld = 1'b0;
    int  nxt_cnt = 0;
    bit  nxt_ovf = 1'b0;
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask
    // uart receiver model: a byte is pending while the queue is non-empty
    initial begin
        u_if.rx_empty = 1'b1;
        u_if.rx_data  = 8'h00;
        forever begin
            @(posedge clk_50Mhz);
            #1;
            if (u_if.uld_rx_data && rxq.size() > 0) u_if.rx_data = rxq.pop_front();
            u_if.rx_empty = rxq.size() == 0;
        end
    end
    // uart transmitter model: accepts a load after `delay` cycles, busy for one cycle after
    initial begin
        u_if.tx_empty = 1'b1;
        forever begin
            @(posedge clk_50Mhz);
            #1;
            if (!u_if.tx_empty) u_if.tx_empty = !stall;
            else if (stall) u_if.tx_empty = 1'b0;
            else if (u_if.ld_tx_data) begin
                tx_wait++;
                if (tx_wait >= delay) begin
                    u_if.tx_empty = 1'b0;
                    tx_wait = 0;
                end
            end else tx_wait = 0;
        end
    end
    initial forever begin
        @(posedge clk_50Mhz);
        rst_seen = reset;
    end
    // monitor: scores accepted bytes and tracks expected occupancy/overflow every cycle
    initial forever begin
        int  e_cnt;
        bit  e_ovf;
        bit  capt;
        bit  acc;
        logic [7:0] e_byte;
        @(negedge clk_50Mhz);
        e_cnt = rst_seen ? 0 : nxt_cnt;
        e_ovf = rst_seen ? 1'b0 : nxt_ovf;
        if (valid || rst_seen) begin
            chk("count_model", int'(count), e_cnt);
            chk("overflow_model", int'(overflow), int'(e_ovf));
            valid = 1'b1;
        end
        capt = prev_uld && !rst_seen;
        acc  = u_if.ld_tx_data && !u_if.tx_empty;
        if (acc) begin
            if (exp_q.size() == 0) chk("unexpected_tx", int'(u_if.tx_data), -1);
            else begin
                e_byte = exp_q.pop_front();
                chk("tx_byte", int'(u_if.tx_data), int'(e_byte));
            end
        end
        nxt_cnt  = e_cnt + int'(capt && e_cnt < 16) - int'(acc);
        nxt_ovf  = e_ovf || (capt && e_cnt == 16);
        prev_uld = u_if.uld_rx_data;
    end
    task automatic send(input logic [7:0] b, input bit expect_out);
        rxq.push_back(b);
        if (expect_out) exp_q.push_back(b);
    endtask
    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk_50Mhz);
    endtask
    task automatic drain(input string name);
        for (int i = 0; i < 2000 && !(exp_q.size() == 0 && count == 0 && !u_if.ld_tx_data); i++)
            @(negedge clk_50Mhz);
        chk(name, int'(exp_q.size() == 0 && count == 0), 1);
    endtask
    initial begin
        logic [7:0] held;
        int n;
        cycles(3);
        chk("rst_uld", int'(u_if.uld_rx_data), 0);
        chk("rst_ld", int'(u_if.ld_tx_data), 0);
        chk("rst_tx_data", int'(u_if.tx_data), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_overflow", int'(overflow), 0);
        reset = 1'b0;
        cycles(2);
        // single byte with latency and pulse shape
        send(8'h41, 1'b1);
        for (int i = 0; i < 10 && u_if.rx_empty; i++) @(negedge clk_50Mhz);
        chk("single_rx_pending", int'(u_if.rx_empty), 0);
        @(negedge clk_50Mhz);
        chk("single_uld_hi", int'(u_if.uld_rx_data), 1);
        @(negedge clk_50Mhz);
        chk("single_uld_lo", int'(u_if.uld_rx_data), 0);
        @(negedge clk_50Mhz);
        chk("single_count1", int'(count), 1);
        chk("single_ld_not_yet", int'(u_if.ld_tx_data), 0);
        @(negedge clk_50Mhz);
        chk("single_ld_hi", int'(u_if.ld_tx_data), 1);
        chk("single_tx_data", int'(u_if.tx_data), 8'h41);
        @(negedge clk_50Mhz);
        chk("single_ld_lo", int'(u_if.ld_tx_data), 0);
        chk("single_count0", int'(count), 0);
        cycles(3);
        // burst with tx stalled
        stall = 1'b1;
        cycles(2);
        for (int i = 0; i < 4; i++) send(8'h10 + 8'(i), 1'b1);
        cycles(20);
        chk("burst_count", int'(count), 4);
        chk("burst_ld_stalled", int'(u_if.ld_tx_data), 0);
        stall = 1'b0;
        drain("burst_drain");
        // full and overflow
        stall = 1'b1;
        cycles(2);
        for (int i = 0; i <= 16; i++) send(8'(i), i < 16);
        cycles(70);
        chk("full_count", int'(count), 16);
        chk("full_overflow", int'(overflow), 1);
        stall = 1'b0;
        drain("full_drain");
        chk("overflow_sticky", int'(overflow), 1);
        // wrap with simultaneous push/pop
        delay = 2;
        for (int i = 0; i < 40; i++) send(8'h80 + 8'(i), 1'b1);
        drain("wrap_drain");
        // hold stability during a long load
        delay = 21;
        send(8'h77, 1'b1);
        for (int i = 0; i < 20 && !u_if.ld_tx_data; i++) @(negedge clk_50Mhz);
        chk("hold_ld_hi", int'(u_if.ld_tx_data), 1);
        chk("hold_tx_data", int'(u_if.tx_data), 8'h77);
        held = u_if.tx_data;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_50Mhz);
            if (!u_if.tx_empty) break;
            n++;
            chk("hold_ld_stable", int'(u_if.ld_tx_data), 1);
            chk("hold_data_stable", int'(u_if.tx_data), int'(held));
            chk("hold_no_pop", int'(count), 1);
        end
        chk("hold_cycles", n, 19);
        drain("hold_drain");
        // reset while loading with three bytes queued
        delay = 1000;
        for (int i = 0; i < 3; i++) send(8'h21 + 8'(i), 1'b0);
        for (int i = 0; i < 100 && !(u_if.ld_tx_data && count == 3); i++) @(negedge clk_50Mhz);
        chk("rstmid_setup", int'(u_if.ld_tx_data && count == 3), 1);
        reset = 1'b1;
        @(negedge clk_50Mhz);
        chk("rstmid_ld", int'(u_if.ld_tx_data), 0);
        chk("rstmid_count", int'(count), 0);
        chk("rstmid_overflow", int'(overflow), 0);
        chk("rstmid_uld", int'(u_if.uld_rx_data), 0);
        reset = 1'b0;
        delay = 1;
        cycles(2);
        send(8'h5A, 1'b1);
        drain("rstmid_echo");
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_echo_fifo.md
Name: uart_echo_fifo

Overview:
Buffered loopback stage between the receive and transmit sides of the uart block. It drains received bytes through the uart unload handshake and stores them in a circular FIFO. It then replays them through the uart transmit load handshake, so bursts arriving faster than they can be sent are not lost. It replaces the unbuffered single-byte echo FSM in the top level and connects port-for-port to the uart rx/tx controls.

Parameters:
ADDR_W, 4, FIFO address width; depth is 2**ADDR_W (16 by default).
DATA_W, 8, byte width; fixed at 8 to match the uart.

Ports:
clk_50Mhz  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk_50Mhz
rx_empty  input  1  from the uart; low means a received byte is waiting to be unloaded
rx_data  input  8  from the uart; byte valid starting the cycle after the uld_rx_data pulse
uld_rx_data  output  1  to the uart; one-cycle unload pulse
tx_empty  input  1  from the uart; high means the transmitter can accept a byte
tx_data  output  8  to the uart; byte to send
ld_tx_data  output  1  to the uart; load request, held until the uart accepts
count  output  ADDR_W+1  FIFO occupancy, 0..2**ADDR_W
overflow  output  1  sticky; a byte was dropped because the FIFO was full

Behaviour:
- Reset: uld_rx_data=0, ld_tx_data=0, tx_data=0, count=0, overflow=0, both pointers=0, both FSMs in IDLE. FIFO RAM contents are don't-care.
- Reset mid-operation: all in-flight bytes are discarded. ld_tx_data and uld_rx_data are 0 after the reset edge.
- All outputs are registered.
- RX FSM, states R_IDLE, R_UNLD, R_CAPT:
  - R_IDLE: if rx_empty==0, go to R_UNLD with uld_rx_data=1.
  - R_UNLD: uld_rx_data=1 for exactly this one cycle. Next state is R_CAPT with uld_rx_data=0.
  - R_CAPT: rx_data is now valid. If not full, write rx_data at wr_ptr on the edge ending this cycle and increment wr_ptr. If full, drop the byte and set overflow=1. Next state is R_IDLE.
  - The minimum spacing between unloads is 3 cycles.
- TX FSM, states T_IDLE, T_LOAD:
  - T_IDLE: if count!=0 and tx_empty==1, set tx_data to the byte at rd_ptr, set ld_tx_data=1, go to T_LOAD.
  - T_LOAD: hold ld_tx_data=1 and tx_data stable while tx_empty==1. On the first cycle with tx_empty==0: ld_tx_data=0 at that edge, pop (rd_ptr+1), go to T_IDLE.
  - There is no timeout; T_LOAD waits indefinitely.
- FIFO:
  - Pointers are ADDR_W bits and wrap modulo 2**ADDR_W.
  - full means count==2**ADDR_W; empty means count==0.
  - Push and pop on the same edge leave count unchanged and both pointers advance.
  - A pop in the same cycle the FIFO is full frees a slot only from the next cycle; a write in R_CAPT that cycle is dropped (full is evaluated on the current count).
  - A byte written at an edge is visible to T_IDLE from the next cycle. Minimum rx-to-tx latency is 4 cycles from rx_empty falling to ld_tx_data rising.
- overflow clears only on reset.
- Byte order is strictly preserved.

Test Plan:
- Single byte: rx_empty falls with 0x41 pending, tx_empty=1 -> one-cycle uld_rx_data; count reaches 1; ld_tx_data rises with tx_data=0x41; on the model dropping tx_empty, ld_tx_data=0 and count=0.
- Burst with tx stalled: tx_empty held 0, bytes 0x10,0x11,0x12,0x13 received -> count=4, ld_tx_data stays 0; release tx_empty -> bytes sent in order 0x10..0x13, count returns to 0.
- Full and overflow: tx stalled, 17 bytes 0x00..0x10 received -> count=16, overflow=1, 0x10 dropped; after release, 0x00..0x0F are sent and overflow stays 1.
- Wrap and simultaneous push/pop: 40 bytes streamed with the uart model accepting each after 2 cycles -> pointers wrap at least twice, output sequence equals input, and count is unchanged on every same-edge push/pop edge.
- Reset in T_LOAD: assert reset while ld_tx_data=1 and count=3 -> next edge gives ld_tx_data=0, count=0, overflow=0; a new byte 0x5A afterwards echoes normally.
- Hold stability: tx_empty kept 1 for 20 cycles in T_LOAD -> tx_data and ld_tx_data constant and no pop until tx_empty falls.
